// File: rtl/tenyr_pkg.sv
// Shared widths, fetch FSM state type and prefetch queue entry layout for the
// fetch stage.
package tenyr_pkg;

    localparam int ADDR_W = 24;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    // Sequential word address; wraps from the top of the address space to zero.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + 24'd1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: circular buffer of {word, pc} entries with push, pop and a
// flush that overrides both.
module fetch_fifo
    import tenyr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           push_entry,
    output fetch_entry_t           head,
    output logic                   head_valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    // Pointer and occupancy update; a push into a full queue only lands alongside a pop.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush) begin
                mem_q[wr_ptr_q] <= push_entry;
            end
        end
    end

    // Head view reads as zero when the queue is empty.
    always_comb begin
        head_valid = (count_q != '0);
        if (head_valid) begin
            head = mem_q[rd_ptr_q];
        end else begin
            head = '0;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory reader feeding a prefetch
// queue to decode. Optional FETCH_ILLEGAL_EN adds insn_illegal and halts fetch
// after an illegal word until the next redirect.
module fetch_unit
    import tenyr_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 24'h000000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              insn_valid,
    input  logic              insn_ready,
    output logic [WORD_W-1:0] insn,
    output logic [ADDR_W-1:0] insn_pc,
`ifdef FETCH_ILLEGAL_EN
    output logic              insn_illegal,
`endif
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] fetch_pc_d;
    logic              mem_req_q;
    logic              mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] mem_addr_d;

    logic              fifo_push;
    logic              fifo_pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    logic              head_valid;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_next;
    logic              credit;
    logic              fetch_halt;

    // Redirect voids any decode handshake in the same cycle.
    assign fifo_pop   = head_valid && insn_ready && !redirect;
    assign fifo_push  = (state_q == REQ) && mem_ack && !redirect;
    assign push_entry = '{word: mem_rdata, pc: mem_addr_q};
    assign count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    // Occupancy after this cycle must leave room for the next outstanding word.
    assign credit     = (count_next < DEPTH_C);

`ifdef FETCH_ILLEGAL_EN
    logic stop_q;
    logic stop_d;
    logic stop_hit;

    assign stop_hit   = fifo_push && mem_rdata[WORD_W-1];
    assign fetch_halt = stop_q || stop_hit;

    // Halt latch: set by an enqueued illegal word, cleared by redirect.
    always_comb begin
        if (redirect) begin
            stop_d = 1'b0;
        end else begin
            stop_d = fetch_halt;
        end
    end

    // Halt latch register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stop_q <= 1'b0;
        end else begin
            stop_q <= stop_d;
        end
    end

    assign insn_illegal = head_entry.word[WORD_W-1];
`else
    assign fetch_halt = 1'b0;
`endif

    // Fetch FSM: the memory handshake is always completed, stale data is dropped.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (credit && !fetch_halt) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    if (mem_ack) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end else begin
                        state_d = DISCARD;
                    end
                end else if (mem_ack) begin
                    fetch_pc_d = next_pc(mem_addr_q);
                    if (credit && !fetch_halt) begin
                        mem_addr_d = next_pc(mem_addr_q);
                    end else begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else begin
                    state_d = DISCARD;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Fetch control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .flush      (redirect),
        .push_entry (push_entry),
        .head       (head_entry),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign insn_valid = head_valid;
    assign insn       = head_entry.word;
    assign insn_pc    = head_entry.pc;

endmodule
